tft_power_sequencer: RTL and testbench

- Controller that sequences the TFT panel power rails, display enable, video enable and backlight duty for tft_driver.
- Driven by a level request from the application.
- Walks the panel through the power-up order: VDD → DISP → video enable on a frame boundary → backlight ramp.
- Power-down runs the exact reverse order.
- Its outputs feed tft_driver's duty_cycle input and gate the panel vdd/display pins.

---
 rtl/tft_pkg.sv | 34 +++
 rtl/tft_duty_ramp.sv | 45 ++++
 rtl/tft_power_sequencer.sv | 101 ++++++++++
 tb/tb_tft_power_sequencer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/tft_pkg.sv
// Shared definitions for the TFT panel power sequencer.
// Holds the FSM state encoding, default timing constants and the duty width.
// Also holds small decode helpers that map a state to the pin levels it implies.
package tft_pkg;

  localparam int          DUTY_W       = 8;
  localparam logic [23:0] T_VDD_DEF    = 24'd100000;
  localparam logic [23:0] T_DISP_DEF   = 24'd50000;
  localparam logic [15:0] RAMP_DIV_DEF = 16'd1000;

  typedef enum logic [3:0] {
    OFF        = 4'd0,
    VDD_UP     = 4'd1,
    DISP_UP    = 4'd2,
    FRAME_WAIT = 4'd3,
    RAMP_UP    = 4'd4,
    ON         = 4'd5,
    RAMP_DOWN  = 4'd6,
    VIDEO_OFF  = 4'd7,
    DISP_DOWN  = 4'd8,
    VDD_DOWN   = 4'd9
  } state_t;

  // The display pin is high from the end of VDD_UP until the end of DISP_DOWN.
  function automatic logic disp_on(input state_t s);
    return s inside {DISP_UP, FRAME_WAIT, RAMP_UP, ON, RAMP_DOWN, VIDEO_OFF, DISP_DOWN};
  endfunction

  // Video is live from the first frame edge after DISP_UP until the frame edge in VIDEO_OFF.
  function automatic logic video_on(input state_t s);
    return s inside {RAMP_UP, ON, RAMP_DOWN, VIDEO_OFF};
  endfunction

endpackage

// File: rtl/tft_duty_ramp.sv
// Backlight duty register with a RAMP_DIV prescaler: steps duty one LSB per prescaler wrap.
// Ports: enable runs the prescaler, direction 1 = move toward target / 0 = move toward zero,
// track loads target directly every cycle, duty is the registered output, at_target compares duty to the goal.
module tft_duty_ramp
  import tft_pkg::*;
#(
  parameter logic [15:0] RAMP_DIV = RAMP_DIV_DEF
) (
  input  logic              cclk,
  input  logic              rst,
  input  logic              enable,
  input  logic              direction,
  input  logic              track,
  input  logic [DUTY_W-1:0] target,
  output logic [DUTY_W-1:0] duty,
  output logic              at_target
);

  localparam logic [15:0] PRE_LAST = RAMP_DIV - 16'd1;

  logic [15:0]       pre;
  logic              tick;
  logic [DUTY_W-1:0] goal;

  // Ramping down always heads for zero, regardless of what the application asks for.
  assign goal      = direction ? target : '0;
  assign at_target = (duty == goal);
  assign tick      = enable && (pre == PRE_LAST);

  always_ff @(posedge cclk) begin
    if (rst) begin
      pre  <= '0;
      duty <= '0;
    end else begin
      // The prescaler keeps its phase while enabled, so an up-to-down reversal does not restart it.
      if (!enable || tick) pre <= '0;
      else                 pre <= pre + 16'd1;

      if (track)                      duty <= target;
      else if (tick && (duty < goal)) duty <= duty + DUTY_W'(1);
      else if (tick && (duty > goal)) duty <= duty - DUTY_W'(1);
    end
  end

endmodule

// File: rtl/tft_power_sequencer.sv
// TFT panel power sequencer: VDD -> DISP -> video on a frame edge -> backlight ramp, and the reverse on power-down.
// Ports: power_on_req level request, bl_target backlight goal, new_frame frame pulse in;
// tft_vdd/tft_display/video_ena/duty_cycle registered controls, ready/busy/state decoded from the state register.
module tft_power_sequencer
  import tft_pkg::*;
#(
  parameter logic [23:0] T_VDD    = T_VDD_DEF,
  parameter logic [23:0] T_DISP   = T_DISP_DEF,
  parameter logic [15:0] RAMP_DIV = RAMP_DIV_DEF,
  parameter int          CNT_W    = 24
) (
  input  logic              cclk,
  input  logic              rst,
  input  logic              power_on_req,
  input  logic [DUTY_W-1:0] bl_target,
  input  logic              new_frame,
  output logic              tft_vdd,
  output logic              tft_display,
  output logic              video_ena,
  output logic [DUTY_W-1:0] duty_cycle,
  output logic              ready,
  output logic              busy,
  output logic [3:0]        state
);

  localparam logic [CNT_W-1:0] VDD_LAST  = CNT_W'(T_VDD - 24'd1);
  localparam logic [CNT_W-1:0] DISP_LAST = CNT_W'(T_DISP - 24'd1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt;
  logic             at_target;
  logic             ramp_en;
  logic             ramp_dir;
  logic             ramp_track;

  assign ramp_en    = (state_q == RAMP_UP) || (state_q == RAMP_DOWN);
  assign ramp_dir   = (state_q == RAMP_UP);
  assign ramp_track = (state_q == ON);

  assign state = state_q;
  assign ready = (state_q == ON);
  assign busy  = (state_q != OFF) && (state_q != ON);

  // Abort checks take priority over timer expiry so a dropped request never raises the next rail.
  // Down states ignore power_on_req entirely: a re-request finishes the full power cycle first.
  always_comb begin
    state_d = state_q;
    case (state_q)
      OFF:        if (power_on_req)        state_d = VDD_UP;
      VDD_UP:     if (!power_on_req)       state_d = VDD_DOWN;
                  else if (cnt == VDD_LAST) state_d = DISP_UP;
      DISP_UP:    if (!power_on_req)       state_d = DISP_DOWN;
                  else if (cnt == DISP_LAST) state_d = FRAME_WAIT;
      FRAME_WAIT: if (!power_on_req)       state_d = DISP_DOWN;
                  else if (new_frame)      state_d = RAMP_UP;
      RAMP_UP:    if (!power_on_req)       state_d = RAMP_DOWN;
                  else if (at_target)      state_d = ON;
      ON:         if (!power_on_req)       state_d = RAMP_DOWN;
      RAMP_DOWN:  if (at_target)           state_d = VIDEO_OFF;
      VIDEO_OFF:  if (new_frame)           state_d = DISP_DOWN;
      DISP_DOWN:  if (cnt == DISP_LAST)    state_d = VDD_DOWN;
      VDD_DOWN:   if (cnt == VDD_LAST)     state_d = OFF;
      default:                             state_d = OFF;
    endcase
  end

  // Pin levels are registered from the next state so each pin moves on the same edge as its transition.
  always_ff @(posedge cclk) begin
    if (rst) begin
      state_q     <= OFF;
      cnt         <= '0;
      tft_vdd     <= 1'b0;
      tft_display <= 1'b0;
      video_ena   <= 1'b0;
    end else begin
      state_q <= state_d;
      // Every state entry restarts the delay count; the count saturates rather than wrapping.
      if (state_d != state_q)  cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
      tft_vdd     <= (state_d != OFF);
      tft_display <= disp_on(state_d);
      video_ena   <= video_on(state_d);
    end
  end

  tft_duty_ramp #(
    .RAMP_DIV (RAMP_DIV)
  ) u_ramp (
    .cclk      (cclk),
    .rst       (rst),
    .enable    (ramp_en),
    .direction (ramp_dir),
    .track     (ramp_track),
    .target    (bl_target),
    .duty      (duty_cycle),
    .at_target (at_target)
  );

endmodule

// File: tb/tb_tft_power_sequencer.sv
// Testbench for tft_power_sequencer with T_VDD=10, T_DISP=5, RAMP_DIV=4.
// Table of {inputs, cycles, expected outputs} records plus hand-written corner sequences.
// Expected outputs are queued when a record is driven and popped when the DUT is sampled.
module tb_tft_power_sequencer;

  localparam logic [3:0] S_OFF = 4'd0, S_VDD_UP = 4'd1, S_DISP_UP = 4'd2, S_FRAME_WAIT = 4'd3,
                         S_RAMP_UP = 4'd4, S_ON = 4'd5, S_RAMP_DOWN = 4'd6, S_VIDEO_OFF = 4'd7,
                         S_DISP_DOWN = 4'd8, S_VDD_DOWN = 4'd9;

  logic       cclk;
  logic       rst;
  logic       power_on_req;
  logic [7:0] bl_target;
  logic       new_frame;
  logic       tft_vdd;
  logic       tft_display;
  logic       video_ena;
  logic [7:0] duty_cycle;
  logic       ready;
  logic       busy;
  logic [3:0] state;

  tft_power_sequencer #(
    .T_VDD    (24'd10),
    .T_DISP   (24'd5),
    .RAMP_DIV (16'd4),
    .CNT_W    (24)
  ) dut (
    .cclk         (cclk),
    .rst          (rst),
    .power_on_req (power_on_req),
    .bl_target    (bl_target),
    .new_frame    (new_frame),
    .tft_vdd      (tft_vdd),
    .tft_display  (tft_display),
    .video_ena    (video_ena),
    .duty_cycle   (duty_cycle),
    .ready        (ready),
    .busy         (busy),
    .state        (state)
  );

  initial begin
    cclk = 1'b0;
    forever #5 cclk = ~cclk;
  end

  typedef struct {
    logic       rst;
    logic       req;
    logic [7:0] bl;
    logic       nf;
    int         cyc;
    logic       vdd;
    logic       disp;
    logic       vid;
    logic [7:0] duty;
    logic [3:0] st;
  } vec_t;

  typedef struct packed {
    logic       vdd;
    logic       disp;
    logic       vid;
    logic [7:0] duty;
    logic       ready;
    logic       busy;
    logic [3:0] st;
  } obs_t;

  vec_t tbl[$];
  obs_t sb[$];
  int   checks = 0;
  int   passes = 0;

  function automatic vec_t mk(input logic r, input logic q, input logic [7:0] b, input logic n,
                              input int c, input logic vd, input logic di, input logic vi,
                              input logic [7:0] du, input logic [3:0] s);
    vec_t v;
    v.rst = r; v.req = q; v.bl = b; v.nf = n; v.cyc = c;
    v.vdd = vd; v.disp = di; v.vid = vi; v.duty = du; v.st = s;
    return v;
  endfunction

  // Drive one record, run its cycles (new_frame is a single-cycle pulse), then compare.
  task automatic apply(input vec_t v, input string tag);
    obs_t e;
    obs_t a;
    rst          = v.rst;
    power_on_req = v.req;
    bl_target    = v.bl;
    new_frame    = v.nf;
    e.vdd   = v.vdd;
    e.disp  = v.disp;
    e.vid   = v.vid;
    e.duty  = v.duty;
    e.ready = (v.st == S_ON);
    e.busy  = (v.st != S_OFF) && (v.st != S_ON);
    e.st    = v.st;
    sb.push_back(e);
    for (int i = 0; i < v.cyc; i++) begin
      @(posedge cclk);
      #1;
      new_frame = 1'b0;
    end
    a.vdd   = tft_vdd;
    a.disp  = tft_display;
    a.vid   = video_ena;
    a.duty  = duty_cycle;
    a.ready = ready;
    a.busy  = busy;
    a.st    = state;
    e = sb.pop_front();
    checks++;
    if (a === e) passes++;
    else $display("FAIL %s: got vdd=%b disp=%b vid=%b duty=%0d ready=%b busy=%b state=%0d, expected vdd=%b disp=%b vid=%b duty=%0d ready=%b busy=%b state=%0d",
                  tag, a.vdd, a.disp, a.vid, a.duty, a.ready, a.busy, a.st,
                  e.vdd, e.disp, e.vid, e.duty, e.ready, e.busy, e.st);
  endtask

  initial begin
    rst = 1'b1; power_on_req = 1'b0; bl_target = 8'd8; new_frame = 1'b0;

    //                rst req bl   nf cyc vdd disp vid duty st
    tbl.push_back(mk(1, 0, 8,   0, 2,  0, 0, 0, 0,   S_OFF));        // reset
    tbl.push_back(mk(0, 1, 8,   0, 1,  1, 0, 0, 0,   S_VDD_UP));     // vdd 1 cycle after request
    tbl.push_back(mk(0, 1, 8,   0, 9,  1, 0, 0, 0,   S_VDD_UP));
    tbl.push_back(mk(0, 1, 8,   0, 1,  1, 1, 0, 0,   S_DISP_UP));    // display 10 cycles after vdd
    tbl.push_back(mk(0, 1, 8,   0, 4,  1, 1, 0, 0,   S_DISP_UP));
    tbl.push_back(mk(0, 1, 8,   1, 1,  1, 1, 0, 0,   S_FRAME_WAIT)); // frame on expiry ignored
    tbl.push_back(mk(0, 1, 8,   0, 3,  1, 1, 0, 0,   S_FRAME_WAIT));
    tbl.push_back(mk(0, 1, 8,   1, 1,  1, 1, 1, 0,   S_RAMP_UP));    // video 1 cycle after pulse
    tbl.push_back(mk(0, 1, 8,   0, 3,  1, 1, 1, 0,   S_RAMP_UP));
    tbl.push_back(mk(0, 1, 8,   0, 1,  1, 1, 1, 1,   S_RAMP_UP));    // first step after 4 cycles
    tbl.push_back(mk(0, 1, 8,   0, 4,  1, 1, 1, 2,   S_RAMP_UP));
    tbl.push_back(mk(0, 1, 8,   0, 24, 1, 1, 1, 8,   S_RAMP_UP));
    tbl.push_back(mk(0, 1, 8,   0, 1,  1, 1, 1, 8,   S_ON));
    tbl.push_back(mk(0, 1, 200, 0, 1,  1, 1, 1, 200, S_ON));         // direct tracking in ON
    tbl.push_back(mk(0, 1, 8,   0, 1,  1, 1, 1, 8,   S_ON));
    tbl.push_back(mk(0, 0, 8,   0, 1,  1, 1, 1, 8,   S_RAMP_DOWN));
    tbl.push_back(mk(0, 0, 50,  0, 4,  1, 1, 1, 7,   S_RAMP_DOWN));  // target change ignored
    tbl.push_back(mk(0, 0, 50,  0, 28, 1, 1, 1, 0,   S_RAMP_DOWN));
    tbl.push_back(mk(0, 0, 50,  0, 1,  1, 1, 1, 0,   S_VIDEO_OFF));
    tbl.push_back(mk(0, 0, 50,  0, 5,  1, 1, 1, 0,   S_VIDEO_OFF));
    tbl.push_back(mk(0, 0, 50,  1, 1,  1, 1, 0, 0,   S_DISP_DOWN));
    tbl.push_back(mk(0, 0, 50,  0, 4,  1, 1, 0, 0,   S_DISP_DOWN));
    tbl.push_back(mk(0, 0, 50,  0, 1,  1, 0, 0, 0,   S_VDD_DOWN));
    tbl.push_back(mk(0, 1, 8,   0, 9,  1, 0, 0, 0,   S_VDD_DOWN));   // re-request mid VDD_DOWN
    tbl.push_back(mk(0, 1, 8,   0, 1,  0, 0, 0, 0,   S_OFF));
    tbl.push_back(mk(0, 1, 8,   0, 1,  1, 0, 0, 0,   S_VDD_UP));     // restart next cycle
    tbl.push_back(mk(0, 1, 8,   0, 10, 1, 1, 0, 0,   S_DISP_UP));
    tbl.push_back(mk(0, 1, 8,   0, 3,  1, 1, 0, 0,   S_DISP_UP));
    tbl.push_back(mk(0, 0, 8,   0, 1,  1, 1, 0, 0,   S_DISP_DOWN));  // abort in DISP_UP
    tbl.push_back(mk(0, 0, 8,   0, 4,  1, 1, 0, 0,   S_DISP_DOWN));
    tbl.push_back(mk(0, 0, 8,   0, 1,  1, 0, 0, 0,   S_VDD_DOWN));
    tbl.push_back(mk(0, 0, 8,   0, 9,  1, 0, 0, 0,   S_VDD_DOWN));
    tbl.push_back(mk(0, 0, 8,   0, 1,  0, 0, 0, 0,   S_OFF));

    for (int k = 0; k < tbl.size(); k++) apply(tbl[k], $sformatf("vec%0d", k));

    // Abort in VDD_UP: display never rises, VDD_DOWN lasts exactly 10 cycles.
    apply(mk(0, 1, 8, 0, 1, 1, 0, 0, 0, S_VDD_UP),   "vdd_abort_up");
    apply(mk(0, 1, 8, 0, 4, 1, 0, 0, 0, S_VDD_UP),   "vdd_abort_hold");
    apply(mk(0, 0, 8, 0, 1, 1, 0, 0, 0, S_VDD_DOWN), "vdd_abort_enter");
    apply(mk(0, 0, 8, 0, 9, 1, 0, 0, 0, S_VDD_DOWN), "vdd_abort_wait");
    apply(mk(0, 0, 8, 0, 1, 0, 0, 0, 0, S_OFF),      "vdd_abort_off");

    // bl_target = 0: RAMP_UP goes straight to ON, RAMP_DOWN straight to VIDEO_OFF.
    apply(mk(0, 1, 0, 0, 1,  1, 0, 0, 0, S_VDD_UP),     "zero_vdd");
    apply(mk(0, 1, 0, 0, 10, 1, 1, 0, 0, S_DISP_UP),    "zero_disp");
    apply(mk(0, 1, 0, 0, 5,  1, 1, 0, 0, S_FRAME_WAIT), "zero_fw");
    apply(mk(0, 1, 0, 1, 1,  1, 1, 1, 0, S_RAMP_UP),    "zero_ramp");
    apply(mk(0, 1, 0, 0, 1,  1, 1, 1, 0, S_ON),         "zero_on");
    apply(mk(0, 0, 0, 0, 1,  1, 1, 1, 0, S_RAMP_DOWN),  "zero_rdown");
    apply(mk(0, 0, 0, 0, 1,  1, 1, 1, 0, S_VIDEO_OFF),  "zero_voff");
    apply(mk(1, 0, 0, 0, 1,  0, 0, 0, 0, S_OFF),        "rst_in_voff");

    // Reset during RAMP_UP at duty 5 drops everything on the next edge.
    apply(mk(0, 1, 8, 0, 1,  1, 0, 0, 0, S_VDD_UP),     "rr_vdd");
    apply(mk(0, 1, 8, 0, 10, 1, 1, 0, 0, S_DISP_UP),    "rr_disp");
    apply(mk(0, 1, 8, 0, 5,  1, 1, 0, 0, S_FRAME_WAIT), "rr_fw");
    apply(mk(0, 1, 8, 1, 1,  1, 1, 1, 0, S_RAMP_UP),    "rr_ramp");
    apply(mk(0, 1, 8, 0, 20, 1, 1, 1, 5, S_RAMP_UP),    "rr_duty5");
    apply(mk(1, 1, 8, 0, 1,  0, 0, 0, 0, S_OFF),        "rr_reset");
    apply(mk(1, 1, 8, 0, 2,  0, 0, 0, 0, S_OFF),        "rr_reset_hold");
    apply(mk(0, 0, 8, 0, 2,  0, 0, 0, 0, S_OFF),        "rr_release");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
